lynx_vram_arbiter: RTL and testbench
====================================

# lynx_vram_arbiter

Time-shares the single-port synchronous video RAM between the Z80 CPU bus (tv80e strobes) and the video fetch engine. Video fetches normally win. A starvation counter guarantees the CPU a slot after a bounded burst of video grants. The CPU is stalled through `cpu_wait_n` until its access completes. The block sits between the CPU bus decode and the VRAM macro in the top level; non-VRAM CPU traffic passes it untouched.

## Interface
- `VRAM_PAGE`, default 2'b11: value of `cpu_addr[15:14]` that selects the VRAM window.
- `MAX_VID_BURST`, default 4 (legal range 1..15): the number of consecutive video grants allowed while a CPU request waits.
- `clk`  in  1  system clock; the arbiter runs every `clk`, not gated by `cen`.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n`  in  1 each  CPU bus strobes, active low.
- `cpu_addr`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  registered CPU read data from VRAM.
- `cpu_wait_n`  out  1  to the core `wait_n`; low stalls the CPU.
- `vid_req`  in  1  video fetch request, level; held until `vid_ack`.
- `vid_addr`  in  14  video fetch address; stable while `vid_req` is high.
- `vid_ack`  out  1  one-`clk` pulse; `vid_data` is valid in this cycle.
- `vid_data`  out  8  registered video read data; held until the next video completion.
- `ram_en`, `ram_we`  out  1 each  VRAM enable and write enable.
- `ram_addr`  out  14  VRAM address.
- `ram_wdata`  out  8  VRAM write data.
- `ram_rdata`  in  8  VRAM read data; valid one `clk` after `ram_en`.

## Operation
- **CPU request:** `cpu_req` = `~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n) & (cpu_addr[15:14]==VRAM_PAGE) & ~served`.
- **`served` flag:** set when a CPU access completes. Cleared in any cycle where `cpu_mreq_n` is 1, so each bus cycle gets exactly one access.
- **Wait output:** `cpu_wait_n` = `~cpu_req`, combinational. Accesses outside the window never stall the CPU.
- **States:** IDLE, CPU_ACC, CPU_DONE, VID_ACC, VID_DONE.
- **IDLE arbitration:**
  - If `cpu_req` and (`vid_req` is 0 or `starve` == `MAX_VID_BURST`), go to CPU_ACC.
  - Else if `vid_req`, go to VID_ACC.
  - Else stay in IDLE.
- **CPU_ACC:**
  - `ram_en`=1, `ram_we`=`~cpu_wr_n`, `ram_addr`=`cpu_addr[13:0]`, `ram_wdata`=`cpu_dout`.
  - Always goes to CPU_DONE.
- **CPU_DONE:**
  - On a read, `cpu_din` <= `ram_rdata`; on a write, `cpu_din` is unchanged.
  - `served` <= 1, `starve` <= 0; go to IDLE.
- **VID_ACC:** `ram_en`=1, `ram_we`=0, `ram_addr`=`vid_addr`; go to VID_DONE.
- **VID_DONE:**
  - `vid_data` <= `ram_rdata`, `vid_ack`=1.
  - If `cpu_req`, `starve` <= min(`starve`+1, `MAX_VID_BURST`); go to IDLE.
- **RAM outputs in other states:** `ram_en`=0 and `ram_we`=0 in IDLE, CPU_DONE and VID_DONE. `ram_addr` and `ram_wdata` are don't-care there.
- **`starve`:** 4-bit, saturating. Cleared on every CPU grant and on reset.
- **CPU strobe drop mid-access:** if `cpu_mreq_n` rises while in CPU_ACC, the access still completes, and `served` is then cleared on the next `mreq_n`-high cycle.
- **Reset:**
  - State <= IDLE; `served`, `starve`, `vid_ack`, `ram_en`, `ram_we` <= 0.
  - `cpu_din`, `vid_data` <= 8'h00.
  - Reset overrides any access in flight, and no `vid_ack` is issued for it.

## Timing
- An access occupies 3 `clk` cycles: IDLE decision, ACC, DONE. Back-to-back grants therefore occur every 3 `clk`.
- **CPU latency:** the request is visible in IDLE at cycle N, RAM is enabled at N+1, `cpu_din` and `served` update at the N+2 edge, and `cpu_wait_n` goes high in cycle N+3.
  - The worst case is an access with video queued ahead of it.
  - A CPU request first seen at N during a video access waits for at most `MAX_VID_BURST` video accesses.
- **Video latency:** with no CPU contention, `vid_ack` is high in cycle N+2 after `vid_req` is sampled in IDLE at N. The requester may change `vid_addr` or drop `vid_req` in the cycle after `vid_ack`.
- **Data stability:** `cpu_din` is stable from `served` until the next CPU read completes. This satisfies the tv80e sampling of `di` at T2 with wait released.
- **Simultaneous requests** with `starve` < `MAX_VID_BURST`: video wins.

## Test plan
- **Idle reset:** reset held for 2 `clk`, all inputs idle → `cpu_wait_n`=1, `ram_en`=0, `vid_ack`=0, `cpu_din`=8'h00, `vid_data`=8'h00.
- **CPU write then read, no video:** CPU writes 8'hA5 to 16'hC123 → `cpu_wait_n` is low for exactly 3 `clk` and `ram_we`=1 with `ram_addr`=14'h0123 for one cycle. A following read of 16'hC123 → `cpu_din`=8'hA5 and `cpu_wait_n` goes high 3 `clk` after `mreq`.
- **Outside window:** CPU read of 16'h4000 → `cpu_wait_n` stays 1 and `ram_en` never asserts.
- **Starvation limit:** `vid_req` held continuously, CPU reads 16'hC000 → exactly 4 `vid_ack` pulses, then one CPU access, then video resumes. `starve` returns to 0.
- **Simultaneous start:** `vid_req`=1 with `vid_addr`=14'h0010, CPU read in the same cycle → the video access goes first (`ram_addr`=14'h0010), then the CPU access. The CPU is stalled for 6 `clk`.
- **Reset mid-access:** reset asserted in VID_ACC → no `vid_ack`, state is IDLE, and the `vid_req` still held is re-served from scratch after reset is released.

Source files
------------

// File: rtl/lynx_vram_arbiter.sv
// lynx_vram_arbiter
// Time-shares the single-port synchronous VRAM between the Z80 CPU bus and the
// video fetch engine. Video normally wins. A saturating starvation counter
// forces a CPU slot after MAX_VID_BURST video grants made while the CPU waits.
// The CPU is held off through cpu_wait_n until its access has completed.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   cpu_mreq_n/rd_n/wr_n       CPU bus strobes (active low)
//   cpu_addr, cpu_dout         CPU address and write data
//   cpu_din                    registered CPU read data
//   cpu_wait_n                 low stalls the CPU (combinational)
//   vid_req, vid_addr          video fetch request (level) and address
//   vid_ack, vid_data          one-cycle completion pulse, registered read data
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata       VRAM macro port (read data one clk after ram_en)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | arbitration decision for the next slot
// CPU_ACC  | RAM enabled with the CPU address/data
// CPU_DONE | capture read data, mark the bus cycle served, clear starve
// VID_ACC  | RAM enabled with the video address
// VID_DONE | capture video data, pulse vid_ack, count starvation
module lynx_vram_arbiter #(
   parameter logic [1:0]  VRAM_PAGE     = 2'b11,
   parameter int unsigned MAX_VID_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_mreq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        cpu_wait_n,
   input  logic        vid_req,
   input  logic [13:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_data,
   output logic        ram_en,
   output logic        ram_we,
   output logic [13:0] ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CPU_ACC  = 3'd1,
      CPU_DONE = 3'd2,
      VID_ACC  = 3'd3,
      VID_DONE = 3'd4
   } state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_VID_BURST);

   state_t     state;
   state_t     state_nxt;
   logic       served;
   logic       acc_wr;
   logic [3:0] starve;
   logic       cpu_req;

   assign cpu_req = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n)
                  & (cpu_addr[15:14] == VRAM_PAGE) & ~served;

   assign cpu_wait_n = ~cpu_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // RAM strobes and vid_ack are gated by reset so an access in flight when
   // reset arrives produces neither a RAM cycle nor a completion pulse.
   always_comb begin
      state_nxt = state;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = vid_addr;
      ram_wdata = cpu_dout;
      vid_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req && (!vid_req || starve == BURST_LIMIT)) begin
               state_nxt = CPU_ACC;
            end else if (vid_req) begin
               state_nxt = VID_ACC;
            end
         end
         CPU_ACC: begin
            ram_en    = ~reset;
            ram_we    = ~reset & ~cpu_wr_n;
            ram_addr  = cpu_addr[13:0];
            state_nxt = CPU_DONE;
         end
         CPU_DONE: begin
            state_nxt = IDLE;
         end
         VID_ACC: begin
            ram_en    = ~reset;
            ram_addr  = vid_addr;
            state_nxt = VID_DONE;
         end
         VID_DONE: begin
            vid_ack   = ~reset;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // acc_wr remembers the access direction so a strobe that drops during the
   // access cannot turn a write into a read capture in CPU_DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         served   <= 1'b0;
         starve   <= 4'd0;
         acc_wr   <= 1'b0;
         cpu_din  <= 8'h00;
         vid_data <= 8'h00;
      end else begin
         if (state == CPU_ACC) begin
            acc_wr <= ~cpu_wr_n;
         end
         if (state == CPU_DONE) begin
            served <= 1'b1;
            starve <= 4'd0;
            if (!acc_wr) begin
               cpu_din <= ram_rdata;
            end
         end else if (cpu_mreq_n) begin
            served <= 1'b0;
         end
         if (state == VID_DONE) begin
            vid_data <= ram_rdata;
            if (cpu_req && starve < BURST_LIMIT) begin
               starve <= starve + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lynx_vram_arbiter.sv
// Self-checking bench for lynx_vram_arbiter: directed vector table, hand-written
// corner sequences, and randomized CPU/video traffic checked against a shadow
// memory that is updated whenever a CPU write completes.
module tb_lynx_vram_arbiter;
   localparam int BURST = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout, cpu_din;
   logic        cpu_wait_n;
   logic        vid_req;
   logic [13:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_data;
   logic        ram_en, ram_we;
   logic [13:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;

   logic [7:0]  vram    [0:16383];
   logic [7:0]  ref_mem [0:16383];
   logic [7:0]  last_din;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lynx_vram_arbiter #(.VRAM_PAGE(2'b11), .MAX_VID_BURST(BURST)) dut (
      .clk(clk), .reset(reset),
      .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
      .cpu_wait_n(cpu_wait_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // VRAM macro stand-in: synchronous single port, read data one clk later
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) vram[ram_addr] <= ram_wdata;
         ram_rdata <= vram[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One CPU bus cycle; reports stall length, video acks seen while stalled,
   // RAM-enable cycles, matching write strobes and the resulting cpu_din.
   task automatic cpu_access(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                             output int waits, output int acks, output int en_cnt,
                             output int we_hit, output logic [7:0] din);
      bit done;
      @(posedge clk); #1;
      cpu_addr   = addr;
      cpu_dout   = data;
      cpu_mreq_n = 1'b0;
      cpu_rd_n   = wr;
      cpu_wr_n   = !wr;
      waits = 0; acks = 0; en_cnt = 0; we_hit = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (ram_en) en_cnt++;
         if (ram_en && ram_we && ram_addr == addr[13:0] && ram_wdata == data) we_hit++;
         if (cpu_wait_n) done = 1'b1;
         else begin
            waits++;
            if (vid_ack) acks++;
         end
      end
      chk("cpu_done", {31'd0, done}, 32'd1);
      din = cpu_din;
      if (done && wr && addr[15:14] == 2'b11) ref_mem[addr[13:0]] = data;
      @(posedge clk); #1;
      cpu_mreq_n = 1'b1;
      cpu_rd_n   = 1'b1;
      cpu_wr_n   = 1'b1;
   endtask

   task automatic vid_agent(input int n, input int max_gap);
      logic [13:0] a;
      bit got;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, max_gap)) @(posedge clk);
         #1;
         a = 14'($urandom_range(0, 31));
         vid_req  = 1'b1;
         vid_addr = a;
         got = 1'b0;
         for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (vid_ack) got = 1'b1;
         end
         chk("vid_ack_seen", {31'd0, got}, 32'd1);
         @(posedge clk); #1;
         chk("vid_data", {24'd0, vid_data}, {24'd0, ref_mem[a]});
         vid_req = 1'b0;
      end
   endtask

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  data;
      int          exp_wait;
      int          exp_en;
      int          exp_we;
      logic [7:0]  exp_din;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int w, k, e, h, first_ack;
      bit ack_seen, done;
      logic [7:0] d;
      logic [13:0] en_addr [0:3];
      logic [15:0] a;
      bit wr;

      vecs[0] = '{1'b1, 16'hC123, 8'hA5, 3, 1, 1, 8'h00};
      vecs[1] = '{1'b0, 16'hC123, 8'h00, 3, 1, 0, 8'hA5};
      vecs[2] = '{1'b0, 16'h4000, 8'h00, 0, 0, 0, 8'hA5};
      vecs[3] = '{1'b1, 16'hC000, 8'h3C, 3, 1, 1, 8'hA5};
      vecs[4] = '{1'b0, 16'hC000, 8'h00, 3, 1, 0, 8'h3C};
      vecs[5] = '{1'b1, 16'h8123, 8'h77, 0, 0, 0, 8'h3C};
      vecs[6] = '{1'b0, 16'hC123, 8'h00, 3, 1, 0, 8'hA5};
      vecs[7] = '{1'b1, 16'hFFFF, 8'h5A, 3, 1, 1, 8'hA5};
      vecs[8] = '{1'b0, 16'hFFFF, 8'h00, 3, 1, 0, 8'h5A};
      vecs[9] = '{1'b0, 16'h0123, 8'h00, 0, 0, 0, 8'h5A};

      reset = 1'b1;
      cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
      cpu_addr = 16'h0000; cpu_dout = 8'h00;
      vid_req = 1'b0; vid_addr = 14'h0000;

      // idle reset
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_wait_n",   {31'd0, cpu_wait_n}, 32'd1);
      chk("rst_ram_en",   {31'd0, ram_en},     32'd0);
      chk("rst_vid_ack",  {31'd0, vid_ack},    32'd0);
      chk("rst_cpu_din",  {24'd0, cpu_din},    32'h00);
      chk("rst_vid_data", {24'd0, vid_data},   32'h00);

      // directed CPU vectors, no video traffic
      for (int i = 0; i < 10; i++) begin
         cpu_access(vecs[i].wr, vecs[i].addr, vecs[i].data, w, k, e, h, d);
         chk($sformatf("vec%0d_wait", i), w, vecs[i].exp_wait);
         chk($sformatf("vec%0d_en", i),   e, vecs[i].exp_en);
         chk($sformatf("vec%0d_we", i),   h, vecs[i].exp_we);
         chk($sformatf("vec%0d_din", i),  {24'd0, d}, {24'd0, vecs[i].exp_din});
      end

      // fill the address range used by video and random traffic
      for (int i = 0; i < 32; i++) begin
         cpu_access(1'b1, 16'hC000 | 16'(i), 8'($urandom), w, k, e, h, d);
         chk("fill_wait", w, 3);
      end
      last_din = d;

      // simultaneous start: video first, then CPU; CPU stalls 6 clk
      @(posedge clk); #1;
      vid_req = 1'b1; vid_addr = 14'h0010;
      cpu_addr = 16'hC000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
      w = 0; e = 0; k = 0; ack_seen = 1'b0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (ram_en && e < 4) begin en_addr[e] = ram_addr; e++; end
         if (vid_ack) begin ack_seen = 1'b1; k++; end
         if (!cpu_wait_n) w++; else done = 1'b1;
         @(posedge clk); #1;
         if (ack_seen) vid_req = 1'b0;
      end
      cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
      chk("sim_wait", w, 6);
      chk("sim_en_count", e, 2);
      chk("sim_first_addr",  {18'd0, en_addr[0]}, 32'h0010);
      chk("sim_second_addr", {18'd0, en_addr[1]}, 32'h0000);
      chk("sim_acks", k, 1);
      chk("sim_cpu_din",  {24'd0, cpu_din},  {24'd0, ref_mem[0]});
      chk("sim_vid_data", {24'd0, vid_data}, {24'd0, ref_mem[16]});
      last_din = cpu_din;

      // reset during VID_ACC
      @(posedge clk); #1;
      vid_req = 1'b1; vid_addr = 14'h0005;
      @(negedge clk);
      @(negedge clk);
      chk("rmid_acc_en", {31'd0, ram_en}, 32'd1);
      reset = 1'b1;
      k = 0;
      repeat (2) begin
         @(negedge clk);
         if (vid_ack) k++;
      end
      chk("rmid_no_ack", k, 0);
      chk("rmid_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rmid_vid_data", {24'd0, vid_data}, 32'h00);
      chk("rmid_cpu_din",  {24'd0, cpu_din},  32'h00);
      @(posedge clk); #1 reset = 1'b0;
      first_ack = 0;
      for (int c = 1; c <= 10 && first_ack == 0; c++) begin
         @(negedge clk);
         if (vid_ack) first_ack = c;
      end
      chk("rmid_reserve_cycle", first_ack, 3);
      @(posedge clk); #1;
      chk("rmid_vid_data_after", {24'd0, vid_data}, {24'd0, ref_mem[5]});
      vid_req = 1'b0;
      last_din = 8'h00;

      // starvation limit under continuous video, twice (starve must reset)
      fork
         vid_agent(16, 0);
         begin
            repeat (4) @(posedge clk);
            cpu_access(1'b0, 16'hC000, 8'h00, w, k, e, h, d);
            chk("starve1_acks", k, BURST);
            chk("starve1_din", {24'd0, d}, {24'd0, ref_mem[0]});
            cpu_access(1'b0, 16'hC001, 8'h00, w, k, e, h, d);
            chk("starve2_acks", k, BURST);
            chk("starve2_din", {24'd0, d}, {24'd0, ref_mem[1]});
            last_din = d;
         end
      join

      // randomized traffic against the shadow memory
      fork
         vid_agent(40, 3);
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 4)) @(posedge clk);
               wr = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 5) == 0)
                  a = {2'($urandom_range(0, 2)), 14'($urandom)};
               else
                  a = {2'b11, 9'd0, 5'($urandom_range(0, 31))};
               cpu_access(wr, a, 8'($urandom), w, k, e, h, d);
               if (a[15:14] != 2'b11) begin
                  chk("rnd_outside_wait", w, 0);
                  chk("rnd_outside_din", {24'd0, d}, {24'd0, last_din});
               end else begin
                  chk("rnd_wait_bound", {31'd0, (w >= 3 && w <= 3 * (BURST + 1))}, 32'd1);
                  chk("rnd_ack_bound",  {31'd0, (k <= BURST)}, 32'd1);
                  if (wr) chk("rnd_wr_din", {24'd0, d}, {24'd0, last_din});
                  else begin
                     chk("rnd_rd_din", {24'd0, d}, {24'd0, ref_mem[a[13:0]]});
                     last_din = ref_mem[a[13:0]];
                  end
               end
            end
         end
      join

      @(negedge clk);
      chk("end_wait_n", {31'd0, cpu_wait_n}, 32'd1);
      chk("end_ram_en", {31'd0, ram_en}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
